// File: rtl/ram_pkg.sv
// Shared definitions for the programmable RAM: controller states and the
// default geometry used when the top is instantiated without overrides.
package ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WIPE = 1'b1
  } ram_state_t;

endpackage

// File: rtl/mem_addr_reg.sv
// Address register: synchronous clear, parallel load, increment with natural
// wrap, otherwise hold. Load wins over increment.
module mem_addr_reg #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_val,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/param_ram.sv
// Programmable RAM with dipswitch programming, bus read/write and a
// whole-memory zero fill that runs one word per cycle.
module param_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  prog_mode,
  input  logic [DATA_WIDTH-1:0] dipswitch_data,
  input  logic [ADDR_WIDTH-1:0] dipswitch_addr,
  input  logic                  prog_write,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  load_addr_reg,
  input  logic                  write_enable,
  input  logic                  output_enable,
  input  logic                  wipe_start,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  busy,
  output logic                  dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  ram_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_wipe_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_idle;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] w_load_val;
  logic                  w_inc;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_unused_bus;

  // Only the low ADDR_WIDTH bits of bus_in ever feed the address register.
  assign w_unused_bus = ^bus_in;

  assign w_idle     = (r_state == IDLE);
  assign w_load     = w_idle & load_addr_reg;
  assign w_load_val = prog_mode ? dipswitch_addr : bus_in[ADDR_WIDTH-1:0];
  assign w_inc      = w_idle & prog_mode & prog_write;
  assign w_wr_en    = w_idle & (prog_mode ? prog_write : write_enable);
  assign w_wr_data  = prog_mode ? dipswitch_data : bus_in;

  mem_addr_reg #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_reg (
    .i_clk      (clk),
    .i_clear    (clear),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_inc      (w_inc),
    .o_addr     (w_addr)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= IDLE;
      r_wipe_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wipe_start) begin
            r_state    <= WIPE;
            r_wipe_cnt <= '0;
          end
        end
        WIPE: begin
          r_wipe_cnt <= r_wipe_cnt + 1'b1;
          if (r_wipe_cnt == {ADDR_WIDTH{1'b1}}) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // No reset on the array: clear only blocks writes, so contents survive it.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (r_state == WIPE) begin
        r_mem[r_wipe_cnt] <= '0;
      end else if (w_wr_en) begin
        r_mem[w_addr] <= w_wr_data;
      end
    end
  end

  assign busy      = (r_state == WIPE);
  assign dbg_state = r_state;
  assign addr_out  = w_addr;
  assign bus_out   = (output_enable && !busy) ? r_mem[w_addr] : '0;

endmodule

// File: tb/tb_param_ram.sv
// Bench for param_ram: directed vector table, wipe/clear sequences and
// randomized traffic, all checked against an array-based reference model.
module tb_param_ram;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic          clr;
    logic          pm;
    logic          pw;
    logic          la;
    logic          we;
    logic          oe;
    logic          ws;
    logic [DW-1:0] dd;
    logic [AW-1:0] da;
    logic [DW-1:0] bi;
  } in_t;

  typedef struct packed {
    in_t           in;
    logic [AW-1:0] e_addr;
    logic          e_busy;
    logic [DW-1:0] e_out;
  } vec_t;

  logic          clk;
  logic          clear;
  logic          prog_mode;
  logic [DW-1:0] dipswitch_data;
  logic [AW-1:0] dipswitch_addr;
  logic          prog_write;
  logic [DW-1:0] bus_in;
  logic          load_addr_reg;
  logic          write_enable;
  logic          output_enable;
  logic          wipe_start;
  logic [DW-1:0] bus_out;
  logic [AW-1:0] addr_out;
  logic          busy;
  logic          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mem [DEPTH];
  int m_addr;
  int m_left;

  vec_t vecs [22];

  param_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .clear          (clear),
    .prog_mode      (prog_mode),
    .dipswitch_data (dipswitch_data),
    .dipswitch_addr (dipswitch_addr),
    .prog_write     (prog_write),
    .bus_in         (bus_in),
    .load_addr_reg  (load_addr_reg),
    .write_enable   (write_enable),
    .output_enable  (output_enable),
    .wipe_start     (wipe_start),
    .bus_out        (bus_out),
    .addr_out       (addr_out),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // Clock and initial input levels
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mi(logic clr, logic pm, logic pw, logic la, logic we,
                             logic oe, logic ws, logic [DW-1:0] dd,
                             logic [AW-1:0] da, logic [DW-1:0] bi);
    in_t v;
    v.clr = clr; v.pm = pm; v.pw = pw; v.la = la; v.we = we;
    v.oe = oe; v.ws = ws; v.dd = dd; v.da = da; v.bi = bi;
    return v;
  endfunction

  function automatic vec_t mkv(in_t i, logic [AW-1:0] ea, logic eb, logic [DW-1:0] eo);
    vec_t v;
    v.in = i; v.e_addr = ea; v.e_busy = eb; v.e_out = eo;
    return v;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: memory as an int array, wipe as "words remaining".
  task automatic model_step(in_t v);
    if (v.clr) begin
      m_addr = 0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_mem[DEPTH - m_left] = 0;
      m_left = m_left - 1;
    end else begin
      if (!v.pm && v.we) m_mem[m_addr] = int'(v.bi);
      if (v.pm && v.pw)  m_mem[m_addr] = int'(v.dd);
      if (v.la)               m_addr = v.pm ? int'(v.da) : int'(v.bi) % DEPTH;
      else if (v.pm && v.pw)  m_addr = (m_addr + 1) % DEPTH;
      if (v.ws) m_left = DEPTH;
    end
  endtask

  // Driver: apply one cycle of inputs, advance model, compare all outputs.
  task automatic apply(in_t v);
    logic [DW-1:0] exp_out;
    clear          = v.clr;
    prog_mode      = v.pm;
    prog_write     = v.pw;
    load_addr_reg  = v.la;
    write_enable   = v.we;
    output_enable  = v.oe;
    wipe_start     = v.ws;
    dipswitch_data = v.dd;
    dipswitch_addr = v.da;
    bus_in         = v.bi;
    model_step(v);
    @(posedge clk);
    #1;
    exp_out = (v.oe && m_left == 0) ? DW'(m_mem[m_addr]) : '0;
    check("model_addr", DW'(addr_out), DW'(m_addr));
    check("model_busy", DW'(busy), DW'(m_left > 0));
    check("model_state", DW'(dbg_state), DW'(m_left > 0));
    check("model_bus_out", bus_out, exp_out);
  endtask

  task automatic read_word(int idx, logic [DW-1:0] exp, string name);
    apply(mi(0, 0, 0, 1, 0, 0, 0, '0, '0, DW'(idx)));
    apply(mi(0, 0, 0, 0, 0, 1, 0, '0, '0, '0));
    check(name, bus_out, exp);
  endtask

  task automatic prog_fill(int base);
    apply(mi(0, 1, 0, 1, 0, 0, 0, '0, '0, '0));
    for (int i = 0; i < DEPTH; i++)
      apply(mi(0, 1, 1, 0, 0, 0, 0, DW'(base + i), '0, '0));
  endtask

  initial begin
    int busy_cycles;
    int guard;
    in_t r;

    clear = 1'b1; prog_mode = 1'b0; prog_write = 1'b0; load_addr_reg = 1'b0;
    write_enable = 1'b0; output_enable = 1'b0; wipe_start = 1'b0;
    dipswitch_data = '0; dipswitch_addr = '0; bus_in = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_addr = 0;
    m_left = 0;

    //                clr pm pw la we oe ws  dd     da     bi
    vecs[0]  = mkv(mi(1, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00), 4'h0, 0, 8'h00);
    vecs[1]  = mkv(mi(0, 1, 1, 0, 0, 0, 0, 8'hCF, 4'h0, 8'h00), 4'h1, 0, 8'h00);
    vecs[2]  = mkv(mi(0, 1, 1, 0, 0, 0, 0, 8'h12, 4'h0, 8'h00), 4'h2, 0, 8'h00);
    vecs[3]  = mkv(mi(0, 1, 1, 0, 0, 0, 0, 8'h34, 4'h0, 8'h00), 4'h3, 0, 8'h00);
    vecs[4]  = mkv(mi(0, 1, 0, 1, 0, 1, 0, 8'h00, 4'h0, 8'h00), 4'h0, 0, 8'hCF);
    vecs[5]  = mkv(mi(0, 1, 0, 1, 0, 1, 0, 8'h00, 4'h1, 8'h00), 4'h1, 0, 8'h12);
    vecs[6]  = mkv(mi(0, 1, 0, 1, 0, 1, 0, 8'h00, 4'h2, 8'h00), 4'h2, 0, 8'h34);
    vecs[7]  = mkv(mi(0, 1, 0, 1, 0, 0, 0, 8'h00, 4'hF, 8'h00), 4'hF, 0, 8'h00);
    vecs[8]  = mkv(mi(0, 1, 1, 0, 0, 0, 0, 8'hAA, 4'h0, 8'h00), 4'h0, 0, 8'h00);
    vecs[9]  = mkv(mi(0, 1, 0, 1, 0, 1, 0, 8'h00, 4'hF, 8'h00), 4'hF, 0, 8'hAA);
    vecs[10] = mkv(mi(0, 0, 0, 1, 0, 0, 0, 8'h00, 4'h0, 8'h05), 4'h5, 0, 8'h00);
    vecs[11] = mkv(mi(0, 0, 0, 0, 1, 0, 0, 8'h00, 4'h0, 8'hF7), 4'h5, 0, 8'h00);
    vecs[12] = mkv(mi(0, 0, 0, 0, 0, 1, 0, 8'h00, 4'h0, 8'h00), 4'h5, 0, 8'hF7);
    vecs[13] = mkv(mi(0, 0, 0, 0, 0, 0, 0, 8'h00, 4'h0, 8'h00), 4'h5, 0, 8'h00);
    vecs[14] = mkv(mi(0, 0, 0, 1, 1, 0, 0, 8'h00, 4'h0, 8'h09), 4'h9, 0, 8'h00);
    vecs[15] = mkv(mi(0, 0, 0, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05), 4'h5, 0, 8'h09);
    vecs[16] = mkv(mi(0, 1, 0, 0, 0, 1, 0, 8'h00, 4'h0, 8'h00), 4'h5, 0, 8'h09);
    vecs[17] = mkv(mi(0, 0, 1, 0, 0, 1, 0, 8'h55, 4'h0, 8'h00), 4'h5, 0, 8'h09);
    vecs[18] = mkv(mi(0, 1, 0, 0, 1, 1, 0, 8'h00, 4'h0, 8'h66), 4'h5, 0, 8'h09);
    vecs[19] = mkv(mi(0, 1, 1, 1, 0, 0, 0, 8'h77, 4'h3, 8'h00), 4'h3, 0, 8'h00);
    vecs[20] = mkv(mi(0, 1, 0, 1, 0, 1, 0, 8'h00, 4'h5, 8'h00), 4'h5, 0, 8'h77);
    vecs[21] = mkv(mi(1, 0, 0, 0, 0, 1, 0, 8'h00, 4'h0, 8'h00), 4'h0, 0, 8'hCF);

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i].in);
      check($sformatf("vec%0d_addr", i), DW'(addr_out), DW'(vecs[i].e_addr));
      check($sformatf("vec%0d_busy", i), DW'(busy), DW'(vecs[i].e_busy));
      check($sformatf("vec%0d_bus_out", i), bus_out, vecs[i].e_out);
    end

    // Full wipe with junk traffic (including wipe_start) while busy
    prog_fill(8'h40);
    apply(mi(0, 1, 0, 1, 0, 0, 0, '0, 4'h6, '0));
    apply(mi(0, 0, 0, 0, 0, 0, 1, '0, '0, '0));
    busy_cycles = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 40) begin
      r = in_t'($urandom());
      r.clr = 1'b0;
      apply(r);
      if (busy) busy_cycles++;
      guard++;
    end
    check("wipe_len", DW'(busy_cycles), DW'(DEPTH));
    check("wipe_addr_hold", DW'(addr_out), 8'h06);
    for (int i = 0; i < DEPTH; i++)
      read_word(i, 8'h00, $sformatf("wipe_zero%0d", i));

    // Clear during wipe cycle 4 aborts the fill
    prog_fill(8'h10);
    apply(mi(0, 1, 0, 1, 0, 0, 0, '0, 4'h7, '0));
    apply(mi(0, 0, 0, 0, 0, 0, 1, '0, '0, '0));
    for (int i = 0; i < 4; i++) apply(mi(0, 0, 0, 0, 0, 0, 0, '0, '0, '0));
    apply(mi(1, 0, 0, 0, 0, 0, 0, '0, '0, '0));
    check("abort_busy", DW'(busy), 8'h00);
    check("abort_addr", DW'(addr_out), 8'h00);
    for (int i = 0; i < DEPTH; i++)
      read_word(i, (i < 4) ? 8'h00 : DW'(8'h10 + i), $sformatf("abort_word%0d", i));

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r = in_t'({$urandom(), $urandom()});
      r.clr = ($urandom_range(0, 49) == 0);
      r.ws  = ($urandom_range(0, 39) == 0);
      apply(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each memory word and of the bus.
REQ-002 Parameter ADDR_WIDTH, default 4: width of the address register; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 clk  input  1: the single clock; all state SHALL change on its rising edge only.
REQ-004 clear  input  1: reset; synchronous, active-high.
REQ-005 prog_mode  input  1: 1 = programming (dipswitch) mode, 0 = run (bus) mode.
REQ-006 dipswitch_data  input  DATA_WIDTH: word to store in programming mode.
REQ-007 dipswitch_addr  input  ADDR_WIDTH: address to load in programming mode.
REQ-008 prog_write  input  1: single-cycle pulse; store dipswitch_data in programming mode.
REQ-009 bus_in  input  DATA_WIDTH: data/address source in run mode.
REQ-010 load_addr_reg  input  1: load the address register.
REQ-011 write_enable  input  1: active-high bus write in run mode.
REQ-012 output_enable  input  1: drive the addressed word onto bus_out.
REQ-013 wipe_start  input  1: single-cycle pulse; start a whole-memory zero fill.
REQ-014 bus_out  output  DATA_WIDTH: read data, zero when not enabled.
REQ-015 addr_out  output  ADDR_WIDTH: current address register value.
REQ-016 busy  output  1: high while a wipe is in progress.

Function
REQ-017 Controller states SHALL be IDLE and WIPE only.
REQ-018 In IDLE, run mode, load_addr_reg: address register SHALL load bus_in[ADDR_WIDTH-1:0].
REQ-019 In IDLE, programming mode, load_addr_reg: address register SHALL load dipswitch_addr.
REQ-020 In IDLE, run mode, write_enable: mem[address] SHALL take bus_in at that edge; prog_write ignored.
REQ-021 In IDLE, programming mode, prog_write: mem[address] SHALL take dipswitch_data, and the address SHALL increment by 1, wrapping from 2**ADDR_WIDTH-1 to 0; write_enable ignored.
REQ-022 Simultaneous write and address load: the write SHALL use the pre-edge address; the register then updates. In programming mode the load SHALL take priority over the auto-increment.
REQ-023 Read SHALL be combinational: bus_out = mem[address] when output_enable=1 and busy=0, else all zeros; a word written at edge N is visible after edge N.
REQ-024 wipe_start in IDLE: state -> WIPE at the next edge, busy=1, internal wipe counter = 0.
REQ-025 In WIPE: one word per cycle SHALL be written to zero at the counter address, counter +1; after address 2**ADDR_WIDTH-1 is written, state -> IDLE and busy=0. The wipe therefore takes exactly 2**ADDR_WIDTH cycles.
REQ-026 In WIPE: load_addr_reg, write_enable, prog_write and wipe_start SHALL be ignored; the address register SHALL hold its value.
REQ-027 wipe_start while already in WIPE SHALL NOT restart the counter.
REQ-028 A mode change during IDLE SHALL take effect in the same cycle and SHALL NOT alter the address register.

Reset
REQ-029 clear SHALL have priority over every other input.
REQ-030 On clear: address register = 0, state = IDLE, busy = 0, wipe counter = 0.
REQ-031 Memory contents SHALL NOT be altered by clear.
REQ-032 clear during WIPE SHALL abort the wipe and leave words not yet zeroed unchanged.

Structure
REQ-033 Shared package ram_pkg SHALL hold the state enum (IDLE, WIPE) and the default DATA_WIDTH and ADDR_WIDTH constants.
REQ-034 The address register SHALL be a sub-module mem_addr_reg (clear, load, increment with wrap, hold), parametrised by ADDR_WIDTH.
REQ-035 Memory SHALL be an inferred register array with no tristate outputs.

Verification
REQ-036 Programming mode: clear; prog_write x3 with data 0xCF, 0x12, 0x34 -> mem[0..2] = CF,12,34, addr_out = 3.
REQ-037 Wrap: load dipswitch_addr 0xF, prog_write 0xAA -> mem[15] = AA, addr_out = 0.
REQ-038 Run mode: bus_in = 0x05 with load_addr_reg, then write_enable with bus_in = 0xF7, then output_enable -> bus_out = F7; with output_enable = 0 -> bus_out = 00.
REQ-039 Same cycle: write_enable plus load_addr_reg with bus_in = 0x09 at address 5 -> mem[5] = 09, addr_out = 9.
REQ-040 wipe_start after filling memory -> busy high for exactly 16 cycles, all words 00 afterwards, writes during the wipe ignored.
REQ-041 clear asserted at wipe cycle 4 -> busy = 0 the next cycle, addr_out = 0, mem[0..3] = 00, mem[4..15] unchanged.
